// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The hold counter is 4 bits wide and saturates at 15.
package regfile_arb_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;
   localparam int HOLD_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arb_state_t;

   function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of both requester handshakes and the register-file write strobe.
// The slave modport is the arbiter side; the master modport is the requester side.
interface regfile_write_arbiter_if;
   import regfile_arb_pkg::*;

   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_lock;
   logic              req0_ready;

   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_lock;
   logic              req1_ready;

   logic              rf_ld;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              owner;
   logic              locked;

   modport slave (
      input  req0_valid, req0_addr, req0_data, req0_lock,
      input  req1_valid, req1_addr, req1_data, req1_lock,
      output req0_ready, req1_ready,
      output rf_ld, rf_addr, rf_data, owner, locked
   );

   modport master (
      output req0_valid, req0_addr, req0_data, req0_lock,
      output req1_valid, req1_addr, req1_data, req1_lock,
      input  req0_ready, req1_ready,
      input  rf_ld, rf_addr, rf_data, owner, locked
   );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker with an override that restricts
// the grant to a single requester (used while a lock is held).
module rr_pick2 (
   input  logic v0,
   input  logic v1,
   input  logic last,
   input  logic force_sel,
   input  logic force_id,
   output logic g0,
   output logic g1
);
   // On a tie the requester that was not served last wins.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (force_sel) begin
         g0 = v0 & ~force_id;
         g1 = v1 &  force_id;
      end else begin
         g0 = v0 & (~v1 |  last);
         g1 = v1 & (~v0 | ~last);
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between two requesters: round-robin
// grants, optional burst lock with a bounded hold, registered one-cycle strobe.
module regfile_write_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input logic                    clk,
   input logic                    rst,
   regfile_write_arbiter_if.slave bus
);
   import regfile_arb_pkg::*;

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

   arb_state_t        state_reg, state_next;
   logic              rr_last_reg, rr_last_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

   logic              rf_ld_reg;
   logic [ADDR_W-1:0] rf_addr_reg;
   logic [DATA_W-1:0] rf_data_reg;
   logic              owner_reg;

   logic force_sel, force_id, g0, g1, acc0, acc1;
   logic other_valid, own_lock, timeout;

   assign force_sel   = (state_reg != ARB_IDLE);
   assign force_id    = (state_reg == ARB_LOCK1);
   assign other_valid = force_id ? bus.req0_valid : bus.req1_valid;
   assign own_lock    = force_id ? bus.req1_lock  : bus.req0_lock;
   assign timeout     = (hold_cnt_reg >= HOLD_LIMIT);

   rr_pick2 u_pick (
      .v0        (bus.req0_valid),
      .v1        (bus.req1_valid),
      .last      (rr_last_reg),
      .force_sel (force_sel),
      .force_id  (force_id),
      .g0        (g0),
      .g1        (g1)
   );

   // Ready is held low for as long as reset is asserted, not just after an edge.
   assign bus.req0_ready = g0 & ~rst;
   assign bus.req1_ready = g1 & ~rst;
   assign acc0 = bus.req0_valid & bus.req0_ready;
   assign acc1 = bus.req1_valid & bus.req1_ready;

   always_comb begin
      state_next    = state_reg;
      rr_last_next  = rr_last_reg;
      hold_cnt_next = sat_inc(hold_cnt_reg);
      if (acc0)
         rr_last_next = 1'b0;
      else if (acc1)
         rr_last_next = 1'b1;
      case (state_reg)
         ARB_IDLE: begin
            hold_cnt_next = '0;
            if (acc0)
               state_next = bus.req0_lock ? ARB_LOCK0 : ARB_IDLE;
            else if (acc1)
               state_next = bus.req1_lock ? ARB_LOCK1 : ARB_IDLE;
         end
         ARB_LOCK0, ARB_LOCK1: begin
            // A waiting competitor past the hold limit forces release, even mid-burst.
            if (other_valid && timeout)
               state_next = ARB_IDLE;
            else if ((acc0 | acc1) && !own_lock)
               state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ARB_IDLE;
         rr_last_reg  <= 1'b1;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         rr_last_reg  <= rr_last_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   // Address and data hold their last values between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_ld_reg   <= 1'b0;
         rf_addr_reg <= '0;
         rf_data_reg <= '0;
         owner_reg   <= 1'b0;
      end else begin
         rf_ld_reg <= acc0 | acc1;
         if (acc0) begin
            rf_addr_reg <= bus.req0_addr;
            rf_data_reg <= bus.req0_data;
            owner_reg   <= 1'b0;
         end else if (acc1) begin
            rf_addr_reg <= bus.req1_addr;
            rf_data_reg <= bus.req1_data;
            owner_reg   <= 1'b1;
         end
      end
   end

   assign bus.rf_ld   = rf_ld_reg;
   assign bus.rf_addr = rf_addr_reg;
   assign bus.rf_data = rf_data_reg;
   assign bus.owner   = owner_reg;
   assign bus.locked  = force_sel;
endmodule
